// File: rtl/vga_frame_output_pkg.sv
// rtl/vga_frame_output_pkg.sv - shared video timing constants, RGB type and colour helpers
package vga_frame_output_pkg;

    typedef logic [7:0] rgb_t;  // RRRGGGBB

    localparam int H_ACTIVE    = 640;
    localparam int H_FP        = 16;
    localparam int H_SYNC      = 96;
    localparam int H_BP        = 48;
    localparam int V_ACTIVE    = 480;
    localparam int V_FP        = 10;
    localparam int V_SYNC      = 2;
    localparam int V_BP        = 33;
    localparam int COORD_WIDTH = 11;
    localparam int PIPE_DELAY  = 2;

    // Replicate the MSB so full-scale 3-bit colour reaches 4'hF on the DAC.
    function automatic logic [3:0] expand3(input logic [2:0] c);
        return {c, c[2]};
    endfunction

    function automatic logic [3:0] expand2(input logic [1:0] c);
        return {c, c};
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// rtl/vga_sync_delay.sv - width x depth shift register with a fixed asynchronous reset value
module vga_sync_delay #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RESET_VAL;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_frame_output.sv
// rtl/vga_frame_output.sv - raster counters, sync generation and delay-aligned VGA pin driver
module vga_frame_output
    import vga_frame_output_pkg::*;
#(
    parameter int H_ACTIVE_P  = H_ACTIVE,
    parameter int H_FP_P      = H_FP,
    parameter int H_SYNC_P    = H_SYNC,
    parameter int H_BP_P      = H_BP,
    parameter int V_ACTIVE_P  = V_ACTIVE,
    parameter int V_FP_P      = V_FP,
    parameter int V_SYNC_P    = V_SYNC,
    parameter int V_BP_P      = V_BP,
    parameter int PIPE_DELAY_P = PIPE_DELAY,
    parameter int CW          = COORD_WIDTH
) (
    input  logic          clk,
    input  logic          resetN,
    input  rgb_t          RGBIn,
    output logic [CW-1:0] pixelX,
    output logic [CW-1:0] pixelY,
    output logic          startOfFrame,
    output logic [3:0]    vga_r,
    output logic [3:0]    vga_g,
    output logic [3:0]    vga_b,
    output logic          hsync,
    output logic          vsync,
    output logic          blankN
);

    localparam int H_TOTAL = H_ACTIVE_P + H_FP_P + H_SYNC_P + H_BP_P;
    localparam int V_TOTAL = V_ACTIVE_P + V_FP_P + V_SYNC_P + V_BP_P;

    localparam logic [CW-1:0] C_H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] C_V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] C_H_ACTIVE   = CW'(H_ACTIVE_P);
    localparam logic [CW-1:0] C_V_ACTIVE   = CW'(V_ACTIVE_P);
    localparam logic [CW-1:0] C_HS_START   = CW'(H_ACTIVE_P + H_FP_P);
    localparam logic [CW-1:0] C_HS_END     = CW'(H_ACTIVE_P + H_FP_P + H_SYNC_P);
    localparam logic [CW-1:0] C_VS_START   = CW'(V_ACTIVE_P + V_FP_P);
    localparam logic [CW-1:0] C_VS_END     = CW'(V_ACTIVE_P + V_FP_P + V_SYNC_P);

    logic [CW-1:0] r_pixel_x;
    logic [CW-1:0] r_pixel_y;
    logic          r_sof;
    logic [CW-1:0] w_next_x;
    logic [CW-1:0] w_next_y;
    logic          w_x_last;
    logic          w_y_last;
    logic          w_visible;
    logic          w_hs_raw;
    logic          w_vs_raw;
    logic [2:0]    w_delayed;
    logic          r_blank_n;
    logic          r_hsync;
    logic          r_vsync;
    logic [3:0]    r_vga_r;
    logic [3:0]    r_vga_g;
    logic [3:0]    r_vga_b;

    always_comb begin
        w_x_last = (r_pixel_x == C_H_LAST);
        w_y_last = (r_pixel_y == C_V_LAST);
        w_next_x = w_x_last ? '0 : r_pixel_x + 1'b1;
        w_next_y = r_pixel_y;
        if (w_x_last) begin
            w_next_y = w_y_last ? '0 : r_pixel_y + 1'b1;
        end
    end

    // Start-of-frame is decoded from the next count so it is high while the counters read (0, V_ACTIVE).
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_pixel_x <= '0;
            r_pixel_y <= '0;
            r_sof     <= 1'b0;
        end else begin
            r_pixel_x <= w_next_x;
            r_pixel_y <= w_next_y;
            r_sof     <= (w_next_x == '0) && (w_next_y == C_V_ACTIVE);
        end
    end

    always_comb begin
        w_visible = (r_pixel_x < C_H_ACTIVE) && (r_pixel_y < C_V_ACTIVE);
        w_hs_raw  = !((r_pixel_x >= C_HS_START) && (r_pixel_x < C_HS_END));
        w_vs_raw  = !((r_pixel_y >= C_VS_START) && (r_pixel_y < C_VS_END));
    end

    vga_sync_delay #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DELAY_P),
        .RESET_VAL (3'b011)
    ) u_sync_delay (
        .clk    (clk),
        .resetN (resetN),
        .i_data ({w_visible, w_hs_raw, w_vs_raw}),
        .o_data (w_delayed)
    );

    // The last delay stage lines up with RGBIn for the same pixel, so both are captured on one edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_blank_n <= 1'b0;
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_vga_r   <= 4'h0;
            r_vga_g   <= 4'h0;
            r_vga_b   <= 4'h0;
        end else begin
            r_blank_n <= w_delayed[2];
            r_hsync   <= w_delayed[1];
            r_vsync   <= w_delayed[0];
            if (w_delayed[2]) begin
                r_vga_r <= expand3(RGBIn[7:5]);
                r_vga_g <= expand3(RGBIn[4:2]);
                r_vga_b <= expand2(RGBIn[1:0]);
            end else begin
                r_vga_r <= 4'h0;
                r_vga_g <= 4'h0;
                r_vga_b <= 4'h0;
            end
        end
    end

    assign pixelX       = r_pixel_x;
    assign pixelY       = r_pixel_y;
    assign startOfFrame = r_sof;
    assign blankN       = r_blank_n;
    assign hsync        = r_hsync;
    assign vsync        = r_vsync;
    assign vga_r        = r_vga_r;
    assign vga_g        = r_vga_g;
    assign vga_b        = r_vga_b;

endmodule

// File: tb/tb_vga_frame_output.sv
// tb/tb_vga_frame_output.sv - directed checks of a reduced-timing instance plus line timing of the default instance
module tb_vga_frame_output;
    import vga_frame_output_pkg::*;

    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
    localparam int D  = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    logic resetN;
    rgb_t rgb_in;
    rgb_t full_rgb;

    logic [10:0] px, py;
    logic        sof, hs, vs, bn;
    logic [3:0]  r, g, b;

    logic [10:0] f_px, f_py;
    logic        f_sof, f_hs, f_vs, f_bn;
    logic [3:0]  f_r, f_g, f_b;

    int n;
    int checks;
    int errors;

    typedef struct {
        int         x;
        int         y;
        logic [7:0] rgb;
        logic       blank_n;
        logic       hs;
        logic       vs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } vec_t;

    vec_t vecs[14];

    vga_frame_output #(
        .H_ACTIVE_P(HA), .H_FP_P(HF), .H_SYNC_P(HS), .H_BP_P(HB),
        .V_ACTIVE_P(VA), .V_FP_P(VF), .V_SYNC_P(VS), .V_BP_P(VB),
        .PIPE_DELAY_P(D), .CW(11)
    ) u_dut (
        .clk(clk), .resetN(resetN), .RGBIn(rgb_in),
        .pixelX(px), .pixelY(py), .startOfFrame(sof),
        .vga_r(r), .vga_g(g), .vga_b(b),
        .hsync(hs), .vsync(vs), .blankN(bn)
    );

    vga_frame_output u_full (
        .clk(clk), .resetN(resetN), .RGBIn(full_rgb),
        .pixelX(f_px), .pixelY(f_py), .startOfFrame(f_sof),
        .vga_r(f_r), .vga_g(f_g), .vga_b(f_b),
        .hsync(f_hs), .vsync(f_vs), .blankN(f_bn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic reset_dut();
        resetN = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
        n = 0;
    endtask

    initial begin
        int hs_fall1, hs_rise, hs_fall2, bn_rise, bn_fall, sof_first, sof_count, target;
        logic prev_hs, prev_bn, vs_low_seen, blank_colour_leak;
        logic [3:0] rise_r, rise_g, rise_b, next_r;

        checks = 0;
        errors = 0;
        n = 0;
        rgb_in = 8'h00;
        full_rgb = 8'hE3;
        resetN = 1'b0;

        vecs[0]  = '{0,  0,  8'hFF, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF};
        vecs[1]  = '{1,  0,  8'hE3, 1'b1, 1'b1, 1'b1, 4'hF, 4'h0, 4'hF};
        vecs[2]  = '{15, 0,  8'h5A, 1'b1, 1'b1, 1'b1, 4'h4, 4'hD, 4'hA};
        vecs[3]  = '{16, 0,  8'hFF, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
        vecs[4]  = '{18, 0,  8'hFF, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0};
        vecs[5]  = '{21, 0,  8'hE3, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0};
        vecs[6]  = '{22, 0,  8'hFF, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
        vecs[7]  = '{3,  2,  8'h92, 1'b1, 1'b1, 1'b1, 4'h9, 4'h9, 4'hA};
        vecs[8]  = '{24, 5,  8'hFF, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
        vecs[9]  = '{5,  6,  8'hFF, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
        vecs[10] = '{0,  7,  8'hFF, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
        vecs[11] = '{20, 8,  8'hFF, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
        vecs[12] = '{0,  9,  8'hFF, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
        vecs[13] = '{10, 10, 8'hFF, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};

        // Reset state of both instances.
        #12;
        chk("rst_px", px, 0);
        chk("rst_py", py, 0);
        chk("rst_sof", sof, 0);
        chk("rst_hs", hs, 1);
        chk("rst_vs", vs, 1);
        chk("rst_bn", bn, 0);
        chk("rst_rgb", {r, g, b}, 0);
        chk("rst_full_pins", {f_hs, f_vs, f_bn, f_r, f_g, f_b}, 15'b110_0000_0000_0000);
        @(negedge clk);
        resetN = 1'b1;
        n = 0;

        // Default 640x480 instance: line timing over the first two lines.
        hs_fall1 = -1; hs_rise = -1; hs_fall2 = -1; bn_rise = -1; bn_fall = -1;
        prev_hs = 1'b1; prev_bn = 1'b0; vs_low_seen = 1'b0; blank_colour_leak = 1'b0;
        rise_r = 0; rise_g = 0; rise_b = 0; next_r = 4'h5;
        while (n < 1500) begin
            tick();
            if (prev_hs && !f_hs) begin
                if (hs_fall1 < 0) hs_fall1 = n;
                else if (hs_fall2 < 0) hs_fall2 = n;
            end
            if (!prev_hs && f_hs && hs_rise < 0) hs_rise = n;
            if (!prev_bn && f_bn && bn_rise < 0) begin
                bn_rise = n; rise_r = f_r; rise_g = f_g; rise_b = f_b;
            end
            if (prev_bn && !f_bn && bn_fall < 0) bn_fall = n;
            if (!f_vs) vs_low_seen = 1'b1;
            if (!f_bn && ({f_r, f_g, f_b} != 12'h000)) blank_colour_leak = 1'b1;
            prev_hs = f_hs;
            prev_bn = f_bn;
        end
        chk("full_hs_fall", hs_fall1, 656 + D + 1);
        chk("full_hs_width", hs_rise - hs_fall1, 96);
        chk("full_hs_period", hs_fall2 - hs_fall1, 800);
        chk("full_bn_rise", bn_rise, D + 1);
        chk("full_bn_width", bn_fall - bn_rise, 640);
        chk("full_rise_rgb", {rise_r, rise_g, rise_b}, 12'hF0F);
        chk("full_vs_idle", vs_low_seen, 0);
        chk("full_blank_colour", blank_colour_leak, 0);

        // Reduced-timing instance: table of pixels checked on the pins.
        reset_dut();
        for (int i = 0; i < 14; i++) begin
            target = vecs[i].y * HT + vecs[i].x + D + 1;
            while (n < target) begin
                rgb_in = (n == target - 1) ? vecs[i].rgb : 8'h00;
                tick();
                chk("sof_frame0", sof, (n == VA * HT));
            end
            rgb_in = 8'h00;
            chk($sformatf("v%0d_px", i), px, n % HT);
            chk($sformatf("v%0d_py", i), py, (n / HT) % VT);
            chk($sformatf("v%0d_bn", i), bn, vecs[i].blank_n);
            chk($sformatf("v%0d_hs", i), hs, vecs[i].hs);
            chk($sformatf("v%0d_vs", i), vs, vecs[i].vs);
            chk($sformatf("v%0d_rgb", i), {r, g, b}, {vecs[i].r, vecs[i].g, vecs[i].b});
        end

        // Colour must drop back to zero the cycle after the (0,0) pixel.
        reset_dut();
        while (n < D + 1) begin
            rgb_in = (n == D) ? 8'hFF : 8'h00;
            tick();
        end
        rgb_in = 8'h00;
        chk("align_first_bn", bn, 1);
        chk("align_first_r", r, 4'hF);
        tick();
        chk("align_next_rgb", {r, g, b}, 0);
        chk("align_next_bn", bn, 1);

        // Second start-of-frame pulse lands one frame after the first.
        while (!sof && n < 2 * FT) tick();
        chk("sof_first_again", n, VA * HT);
        tick();
        while (!sof && n < 2 * FT) tick();
        chk("sof_period", n, FT + VA * HT);

        // Asynchronous reset in the middle of a visible line.
        rgb_in = 8'hFF;
        while (n < 2 * FT + 3 * HT + 7) tick();
        chk("mid_pre_px", px, 7);
        chk("mid_pre_py", py, 3);
        chk("mid_pre_pins", {bn, r}, 5'b1_1111);
        #2;
        resetN = 1'b0;
        #1;
        chk("mid_rst_px", px, 0);
        chk("mid_rst_py", py, 0);
        chk("mid_rst_pins", {sof, hs, vs, bn}, 4'b0110);
        chk("mid_rst_rgb", {r, g, b}, 0);
        @(posedge clk);
        #1;
        chk("mid_hold_pins", {px, hs, bn}, {11'd0, 2'b10});
        @(negedge clk);
        resetN = 1'b1;
        n = 0;
        rgb_in = 8'h00;
        chk("mid_rel_xy", {px, py}, 0);
        sof_first = -1;
        sof_count = 0;
        while (n < VA * HT + HT) begin
            tick();
            if (sof) begin
                sof_count++;
                if (sof_first < 0) sof_first = n;
            end
        end
        chk("mid_sof_first", sof_first, VA * HT);
        chk("mid_sof_count", sof_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1);
    end

endmodule
